// File: rtl/neuron_act_if.sv
// Handshake/bus bundle between the neuron activation stage, the 4-bit MAC,
// the upstream operand feeder and the next-layer consumer.
//
// Signals:
//   mac_en      feeder -> neuron : copy of the enable presented to the MAC
//   mac_result  MAC    -> neuron : accumulator value (ACC_W bits)
//   bias        cfg    -> neuron : unsigned per-neuron bias (ACC_W bits)
//   mac_clr     neuron -> MAC    : one-cycle clear of the accumulator
//   mac_hold    neuron -> feeder : no mac_en while high
//   out_data    neuron -> next   : activation (OUT_W bits)
//   out_sat     neuron -> next   : activation was clipped to the maximum
//   out_valid   neuron -> next   : output register holds data
//   out_ready   next   -> neuron : consumer accepts data
//
// Modports: master = neuron side, slave = environment side.
interface neuron_act_if #(
    parameter int unsigned ACC_W = 10,
    parameter int unsigned OUT_W = 4
);
    logic             mac_en;
    logic [ACC_W-1:0] mac_result;
    logic [ACC_W-1:0] bias;
    logic             mac_clr;
    logic             mac_hold;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  mac_en, mac_result, bias, out_ready,
        output mac_clr, mac_hold, out_data, out_sat, out_valid
    );

    modport slave (
        output mac_en, mac_result, bias, out_ready,
        input  mac_clr, mac_hold, out_data, out_sat, out_valid
    );
endinterface

// File: rtl/neuron_act.sv
// Neuron activation stage downstream of the 4-bit MAC.
// Counts N_INPUTS accepted MAC beats, latches the finished dot product and the
// bias, computes ReLU((sum - bias) >> SHIFT) clipped to OUT_W bits and offers
// it on a valid/ready output register. Clears the MAC after each vector and
// holds the operand feeder while a result is in flight or stalled.
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  neuron_act_if.master (mac_en, mac_result, bias, mac_clr, mac_hold,
//        out_data, out_sat, out_valid, out_ready)
//
// Build option: define ACT_ROUND_EN to round half up before requantising
// instead of truncating.
module neuron_act #(
    parameter int unsigned N_INPUTS = 4,
    parameter int unsigned ACC_W    = 10,
    parameter int unsigned SHIFT    = 4,
    parameter int unsigned OUT_W    = 4
) (
    input logic         clk,
    input logic         rst,
    neuron_act_if.master bus
);

    localparam int unsigned     CntW    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N_INPUTS - 1);
    localparam logic [ACC_W:0]  QMax    = (ACC_W + 1)'((1 << OUT_W) - 1);
`ifdef ACT_ROUND_EN
    localparam logic [ACC_W:0]  RndAdd  = (ACC_W + 1)'(1 << (SHIFT - 1));
`endif

    typedef enum logic [1:0] {StAcc, StLatch, StCalc} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [ACC_W-1:0] sample_q;
    logic [ACC_W-1:0] bias_q;
    logic             clr_q;
    logic             hold_q;
    logic             valid_q;
    logic             sat_q;
    logic [OUT_W-1:0] data_q;

    logic signed [ACC_W:0] diff;
    logic [ACC_W:0]        mag;
    logic [ACC_W:0]        shifted;
    logic [OUT_W-1:0]      q;
    logic                  q_sat;
    logic                  load;

    // Requantisation of the latched sample; only meaningful in StCalc.
    always_comb begin
        diff  = $signed({1'b0, sample_q}) - $signed({1'b0, bias_q});
        // For positive diff the extra bit gives headroom for the rounding add.
        mag   = $unsigned(diff);
`ifdef ACT_ROUND_EN
        shifted = (mag + RndAdd) >> SHIFT;
`else
        shifted = mag >> SHIFT;
`endif
        q     = '0;
        q_sat = 1'b0;
        if (!diff[ACC_W] && (diff != '0)) begin
            if (shifted > QMax) begin
                q     = '1;
                q_sat = 1'b1;
            end else begin
                q = shifted[OUT_W-1:0];
            end
        end
    end

    assign load = (state_q == StCalc) && (!valid_q || bus.out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StAcc;
            cnt_q    <= '0;
            sample_q <= '0;
            bias_q   <= '0;
            clr_q    <= 1'b1;  // flush whatever the MAC holds
            hold_q   <= 1'b0;
            valid_q  <= 1'b0;
            sat_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            clr_q <= 1'b0;
            // Accept drains the register; a load below takes priority.
            if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                StAcc: begin
                    if (bus.mac_en) begin
                        if (cnt_q == CntLast) begin
                            cnt_q   <= '0;
                            hold_q  <= 1'b1;
                            state_q <= StLatch;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StLatch: begin
                    sample_q <= bus.mac_result;
                    bias_q   <= bus.bias;
                    clr_q    <= 1'b1;
                    state_q  <= StCalc;
                end
                StCalc: begin
                    if (load) begin
                        data_q  <= q;
                        sat_q   <= q_sat;
                        valid_q <= 1'b1;
                        hold_q  <= 1'b0;
                        state_q <= StAcc;
                    end
                end
                default: state_q <= StAcc;
            endcase
        end
    end

    assign bus.mac_clr   = clr_q;
    assign bus.mac_hold  = hold_q;
    assign bus.out_data  = data_q;
    assign bus.out_sat   = sat_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_neuron_act.sv
// Directed bench for neuron_act with a behavioural 4-bit MAC upstream.
module tb_neuron_act;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [9:0] acc;
    int         n_cmp;
    int         n_err;

    neuron_act_if #(.ACC_W(10), .OUT_W(4)) bus ();

    neuron_act #(
        .N_INPUTS(4),
        .ACC_W   (10),
        .SHIFT   (4),
        .OUT_W   (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream MAC: mac_clr drives its reset, so clear wins over enable.
    always_ff @(posedge clk) begin
        if (bus.mac_clr) acc <= '0;
        else if (bus.mac_en) acc <= acc + ({6'b0, a} * {6'b0, b});
    end
    assign bus.mac_result = acc;

`ifdef ACT_ROUND_EN
    localparam logic [3:0] ExpNorm = 4'd4;
    localparam logic [3:0] TabD [6] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd15, 4'd15};
    localparam logic       TabS [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    localparam logic [3:0] ExpNorm = 4'd3;
    localparam logic [3:0] TabD [6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd15, 4'd15};
    localparam logic       TabS [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    localparam logic [3:0] TabA [6] = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd15, 4'd15};
    localparam logic [3:0] TabB [6] = '{4'd7, 4'd7, 4'd7, 4'd7, 4'd15, 4'd15};
    localparam logic [9:0] TabBias [6] = '{10'd100, 10'd56, 10'd48, 10'd32, 10'd645, 10'd644};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] aa, input logic [3:0] bb);
        a = aa;
        b = bb;
        bus.mac_en = 1'b1;
        step();
        bus.mac_en = 1'b0;
    endtask

    // Four beats then two cycles: returns at T+3 where the result is loaded.
    task automatic vector(input logic [3:0] aa, input logic [3:0] bb);
        for (int i = 0; i < 4; i++) beat(aa, bb);
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mac_en = 1'b0;
        bus.out_ready = 1'b0;
        bus.bias = '0;
        a = '0;
        b = '0;
        step();
        step();
        n_cmp++; if (bus.mac_clr !== 1'b1) begin n_err++; $display("FAIL rst_clr: got %b want 1", bus.mac_clr); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 4'd0) begin n_err++; $display("FAIL rst_data: got %0d want 0", bus.out_data); end
        n_cmp++; if (bus.out_sat !== 1'b0) begin n_err++; $display("FAIL rst_sat: got %b want 0", bus.out_sat); end
        n_cmp++; if (bus.mac_hold !== 1'b0) begin n_err++; $display("FAIL rst_hold: got %b want 0", bus.mac_hold); end
        rst = 1'b0;
        step();
        step();
        n_cmp++; if (bus.mac_clr !== 1'b0) begin n_err++; $display("FAIL rst_clr_drop: got %b want 0", bus.mac_clr); end
    endtask

    task automatic test_saturation();
        bus.out_ready = 1'b1;
        bus.bias = 10'd0;
        for (int i = 0; i < 4; i++) beat(4'd15, 4'd15);
        // T+1: LATCH
        n_cmp++; if (bus.mac_hold !== 1'b1) begin n_err++; $display("FAIL sat_hold_t1: got %b want 1", bus.mac_hold); end
        n_cmp++; if (bus.mac_clr !== 1'b0) begin n_err++; $display("FAIL sat_clr_t1: got %b want 0", bus.mac_clr); end
        step();
        // T+2: CALC, clear pulse
        n_cmp++; if (bus.mac_clr !== 1'b1) begin n_err++; $display("FAIL sat_clr_t2: got %b want 1", bus.mac_clr); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL sat_valid_t2: got %b want 0", bus.out_valid); end
        step();
        // T+3: result
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL sat_valid_t3: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 4'd15) begin n_err++; $display("FAIL sat_data: got %0d want 15", bus.out_data); end
        n_cmp++; if (bus.out_sat !== 1'b1) begin n_err++; $display("FAIL sat_flag: got %b want 1", bus.out_sat); end
        n_cmp++; if (bus.mac_clr !== 1'b0) begin n_err++; $display("FAIL sat_clr_t3: got %b want 0", bus.mac_clr); end
        n_cmp++; if (bus.mac_hold !== 1'b0) begin n_err++; $display("FAIL sat_hold_t3: got %b want 0", bus.mac_hold); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL sat_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_normal();
        bus.out_ready = 1'b1;
        bus.bias = 10'd0;
        vector(4'd2, 4'd7);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL norm_valid: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_data !== ExpNorm) begin n_err++; $display("FAIL norm_data: got %0d want %0d", bus.out_data, ExpNorm); end
        n_cmp++; if (bus.out_sat !== 1'b0) begin n_err++; $display("FAIL norm_sat: got %b want 0", bus.out_sat); end
        step();
    endtask

    task automatic test_bias_table();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.bias = TabBias[i];
            vector(TabA[i], TabB[i]);
            n_cmp++; if (bus.out_data !== TabD[i]) begin n_err++; $display("FAIL bias_data[%0d]: got %0d want %0d", i, bus.out_data, TabD[i]); end
            n_cmp++; if (bus.out_sat !== TabS[i]) begin n_err++; $display("FAIL bias_sat[%0d]: got %b want %b", i, bus.out_sat, TabS[i]); end
        end
        step();
        bus.bias = 10'd0;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        bus.bias = 10'd0;
        vector(4'd2, 4'd7);
        n_cmp++; if (bus.out_data !== ExpNorm) begin n_err++; $display("FAIL bp_v1: got %0d want %0d", bus.out_data, ExpNorm); end
        n_cmp++; if (bus.mac_hold !== 1'b0) begin n_err++; $display("FAIL bp_hold_acc: got %b want 0", bus.mac_hold); end
        vector(4'd15, 4'd15);
        step();
        step();
        n_cmp++; if (bus.mac_hold !== 1'b1) begin n_err++; $display("FAIL bp_hold_stall: got %b want 1", bus.mac_hold); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_stall: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_data !== ExpNorm) begin n_err++; $display("FAIL bp_data_stall: got %0d want %0d", bus.out_data, ExpNorm); end
        n_cmp++; if (bus.out_sat !== 1'b0) begin n_err++; $display("FAIL bp_sat_stall: got %b want 0", bus.out_sat); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_v2: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 4'd15) begin n_err++; $display("FAIL bp_data_v2: got %0d want 15", bus.out_data); end
        n_cmp++; if (bus.out_sat !== 1'b1) begin n_err++; $display("FAIL bp_sat_v2: got %b want 1", bus.out_sat); end
        n_cmp++; if (bus.mac_hold !== 1'b0) begin n_err++; $display("FAIL bp_hold_v2: got %b want 0", bus.mac_hold); end
        step();
        n_cmp++; if (bus.out_data !== 4'd15) begin n_err++; $display("FAIL bp_stable: got %0d want 15", bus.out_data); end
        bus.out_ready = 1'b1;
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.bias = 10'd0;
        vector(4'd2, 4'd7);  // leaves a pending output
        beat(4'd15, 4'd15);
        beat(4'd15, 4'd15);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.mac_clr !== 1'b1) begin n_err++; $display("FAIL mid_clr: got %b want 1", bus.mac_clr); end
        n_cmp++; if (bus.mac_hold !== 1'b0) begin n_err++; $display("FAIL mid_hold: got %b want 0", bus.mac_hold); end
        step();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            beat(4'd2, 4'd7);
            n_cmp++; if (bus.mac_hold !== (i == 3)) begin n_err++; $display("FAIL mid_hold_beat[%0d]: got %b want %b", i, bus.mac_hold, i == 3); end
        end
        step();
        step();
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL mid_valid_after: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_data !== ExpNorm) begin n_err++; $display("FAIL mid_data: got %0d want %0d", bus.out_data, ExpNorm); end
        step();
    endtask

    task automatic test_hold_violation();
        bus.out_ready = 1'b1;
        bus.bias = 10'd0;
        for (int i = 0; i < 4; i++) beat(4'd2, 4'd7);
        // Illegal beats during LATCH and CALC.
        a = 4'd15;
        b = 4'd15;
        bus.mac_en = 1'b1;
        step();
        step();
        bus.mac_en = 1'b0;
        n_cmp++; if (bus.out_data !== ExpNorm) begin n_err++; $display("FAIL hv_data1: got %0d want %0d", bus.out_data, ExpNorm); end
        for (int i = 0; i < 4; i++) begin
            beat(4'd2, 4'd7);
            n_cmp++; if (bus.mac_hold !== (i == 3)) begin n_err++; $display("FAIL hv_hold_beat[%0d]: got %b want %b", i, bus.mac_hold, i == 3); end
        end
        step();
        step();
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL hv_valid2: got %b want 1", bus.out_valid); end
        n_cmp++; if (bus.out_data !== ExpNorm) begin n_err++; $display("FAIL hv_data2: got %0d want %0d", bus.out_data, ExpNorm); end
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_saturation();
        test_normal();
        test_bias_table();
        test_back_to_back();
        test_reset_mid();
        test_hold_violation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
